// File: rtl/rs_entry_if.sv
// Dispatch/CDB/issue bundle for one reservation-station slot.
// The dispatcher drives the master side; the slot drives the issue packet back.
interface rs_entry_if #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5,
  parameter int MISC_W = 64
);
  // ID packet: operands, destination and opaque pass-through fields
  logic [XLEN-1:0]   id_rs1_value;
  logic [XLEN-1:0]   id_rs2_value;
  logic [4:0]        id_dest_reg_idx;
  logic [MISC_W-1:0] id_misc;
  // Map-table packet
  logic [TAG_W-1:0]  mt_rs1_tag;
  logic [TAG_W-1:0]  mt_rs2_tag;
  logic              mt_rs1_ready;
  logic              mt_rs2_ready;
  // Common data bus
  logic [TAG_W-1:0]  cdb_reg_tag;
  logic [XLEN-1:0]   cdb_reg_value;
  // ROB packet
  logic [TAG_W-1:0]  rob_entry;
  logic [XLEN-1:0]   rob_rs1_value;
  logic [XLEN-1:0]   rob_rs2_value;
  // Issue packet
  logic [XLEN-1:0]   is_rs1_value;
  logic [XLEN-1:0]   is_rs2_value;
  logic [4:0]        is_dest_reg_idx;
  logic [MISC_W-1:0] is_misc;
  logic [TAG_W-1:0]  is_rob_entry;

  modport master (
    output id_rs1_value, id_rs2_value, id_dest_reg_idx, id_misc,
           mt_rs1_tag, mt_rs2_tag, mt_rs1_ready, mt_rs2_ready,
           cdb_reg_tag, cdb_reg_value,
           rob_entry, rob_rs1_value, rob_rs2_value,
    input  is_rs1_value, is_rs2_value, is_dest_reg_idx, is_misc, is_rob_entry
  );

  modport slave (
    input  id_rs1_value, id_rs2_value, id_dest_reg_idx, id_misc,
           mt_rs1_tag, mt_rs2_tag, mt_rs1_ready, mt_rs2_ready,
           cdb_reg_tag, cdb_reg_value,
           rob_entry, rob_rs1_value, rob_rs2_value,
    output is_rs1_value, is_rs2_value, is_dest_reg_idx, is_misc, is_rob_entry
  );
endinterface

// File: rtl/rs_entry.sv
// Single reservation-station slot: latches a dispatched instruction, snoops the
// CDB for outstanding operand tags and flags ready-to-issue until cleared.
module rs_entry #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5,
  parameter int MISC_W = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  rs_entry_if.slave  bus,
  output logic       busy,
  output logic       ready
);
  logic              busy_q, busy_d;
  logic [1:0]        vld_q, vld_d;
  logic [TAG_W-1:0]  tag_q [2];
  logic [TAG_W-1:0]  tag_d [2];
  logic [XLEN-1:0]   val_q [2];
  logic [XLEN-1:0]   val_d [2];
  logic [4:0]        dest_q, dest_d;
  logic [MISC_W-1:0] misc_q, misc_d;
  logic [TAG_W-1:0]  robe_q, robe_d;

  logic [TAG_W-1:0]  ld_tag [2];
  logic [1:0]        ld_rdy;
  logic [XLEN-1:0]   rf_val [2];
  logic [XLEN-1:0]   rob_val [2];
  logic              cdb_live;

  assign ld_tag[0]  = bus.mt_rs1_tag;
  assign ld_tag[1]  = bus.mt_rs2_tag;
  assign ld_rdy     = {bus.mt_rs2_ready, bus.mt_rs1_ready};
  assign rf_val[0]  = bus.id_rs1_value;
  assign rf_val[1]  = bus.id_rs2_value;
  assign rob_val[0] = bus.rob_rs1_value;
  assign rob_val[1] = bus.rob_rs2_value;
  assign cdb_live   = (bus.cdb_reg_tag != '0);

  always_comb begin
    busy_d = busy_q;
    vld_d  = vld_q;
    tag_d  = tag_q;
    val_d  = val_q;
    dest_d = dest_q;
    misc_d = misc_q;
    robe_d = robe_q;
    if (enable) begin
      busy_d = 1'b1;
      dest_d = bus.id_dest_reg_idx;
      misc_d = bus.id_misc;
      robe_d = bus.rob_entry;
      for (int i = 0; i < 2; i++) begin
        tag_d[i] = ld_tag[i];
        if (ld_tag[i] == '0) begin
          val_d[i] = rf_val[i];
          vld_d[i] = 1'b1;
        end else if (ld_rdy[i]) begin
          val_d[i] = rob_val[i];
          vld_d[i] = 1'b1;
        end else if (cdb_live && bus.cdb_reg_tag == ld_tag[i]) begin
          // Producer broadcasting in the dispatch cycle would otherwise be missed
          val_d[i] = bus.cdb_reg_value;
          vld_d[i] = 1'b1;
        end else begin
          vld_d[i] = 1'b0;
        end
      end
    end else if (clear) begin
      busy_d = 1'b0;
      vld_d  = '0;
      for (int i = 0; i < 2; i++) tag_d[i] = '0;
    end else if (busy_q) begin
      for (int i = 0; i < 2; i++) begin
        if (!vld_q[i] && cdb_live && bus.cdb_reg_tag == tag_q[i]) begin
          val_d[i] = bus.cdb_reg_value;
          vld_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      vld_q  <= '0;
      dest_q <= '0;
      misc_q <= '0;
      robe_q <= '0;
      for (int i = 0; i < 2; i++) begin
        tag_q[i] <= '0;
        val_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      vld_q  <= vld_d;
      dest_q <= dest_d;
      misc_q <= misc_d;
      robe_q <= robe_d;
      for (int i = 0; i < 2; i++) begin
        tag_q[i] <= tag_d[i];
        val_q[i] <= val_d[i];
      end
    end
  end

  assign busy                = busy_q;
  assign ready               = busy_q & vld_q[0] & vld_q[1];
  assign bus.is_rs1_value    = val_q[0];
  assign bus.is_rs2_value    = val_q[1];
  assign bus.is_dest_reg_idx = dest_q;
  assign bus.is_misc         = misc_q;
  assign bus.is_rob_entry    = robe_q;
endmodule

// File: tb/tb_rs_entry.sv
// Randomized and directed bench for rs_entry against a slot-level reference model.
module tb_rs_entry;
  localparam int XLEN = 32, TAG_W = 5, MISC_W = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic busy, ready;

  rs_entry_if #(.XLEN(XLEN), .TAG_W(TAG_W), .MISC_W(MISC_W)) bus ();

  rs_entry #(.XLEN(XLEN), .TAG_W(TAG_W), .MISC_W(MISC_W)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .clear  (clear),
    .bus    (bus.master),
    .busy   (busy),
    .ready  (ready)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what the slot is holding, in instruction-level terms
  bit              m_busy;
  bit              m_known [2];
  logic [TAG_W-1:0] m_wait [2];
  logic [XLEN-1:0] m_val [2];
  logic [4:0]      m_dest;
  logic [MISC_W-1:0] m_misc;
  logic [TAG_W-1:0] m_robe;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_dest = '0;
    m_misc = '0;
    m_robe = '0;
    for (int i = 0; i < 2; i++) begin
      m_known[i] = 0;
      m_wait[i]  = '0;
      m_val[i]   = '0;
    end
  endtask

  // Apply one clock edge's worth of the slot rules to the model
  task automatic model_step();
    logic [TAG_W-1:0] t [2];
    bit               r [2];
    logic [XLEN-1:0]  rf [2];
    logic [XLEN-1:0]  rb [2];
    t[0] = bus.mt_rs1_tag;   t[1] = bus.mt_rs2_tag;
    r[0] = bus.mt_rs1_ready; r[1] = bus.mt_rs2_ready;
    rf[0] = bus.id_rs1_value;  rf[1] = bus.id_rs2_value;
    rb[0] = bus.rob_rs1_value; rb[1] = bus.rob_rs2_value;
    if (enable) begin
      m_busy = 1;
      m_dest = bus.id_dest_reg_idx;
      m_misc = bus.id_misc;
      m_robe = bus.rob_entry;
      for (int i = 0; i < 2; i++) begin
        m_wait[i]  = t[i];
        m_known[i] = 1;
        if (t[i] == 0)                  m_val[i] = rf[i];
        else if (r[i])                  m_val[i] = rb[i];
        else if (bus.cdb_reg_tag == t[i]) m_val[i] = bus.cdb_reg_value;
        else                            m_known[i] = 0;
      end
    end else if (clear) begin
      m_busy = 0;
      m_known[0] = 0;
      m_known[1] = 0;
    end else if (m_busy && bus.cdb_reg_tag != 0) begin
      for (int i = 0; i < 2; i++)
        if (!m_known[i] && m_wait[i] == bus.cdb_reg_tag) begin
          m_known[i] = 1;
          m_val[i]   = bus.cdb_reg_value;
        end
    end
  endtask

  task automatic check_outputs();
    bit m_ready;
    m_ready = m_busy && m_known[0] && m_known[1];
    chk("busy", 64'(busy), 64'(m_busy));
    chk("ready", 64'(ready), 64'(m_ready));
    chk("rob_entry", 64'(bus.is_rob_entry), 64'(m_robe));
    chk("dest", 64'(bus.is_dest_reg_idx), 64'(m_dest));
    chk("misc", bus.is_misc, m_misc);
    if (m_busy && m_known[0]) chk("rs1_value", 64'(bus.is_rs1_value), 64'(m_val[0]));
    if (m_busy && m_known[1]) chk("rs2_value", 64'(bus.is_rs2_value), 64'(m_val[1]));
  endtask

  task automatic set_in(input bit en, input bit clr,
                        input int t1, input bit r1, input int t2, input bit r2,
                        input int ct, input logic [XLEN-1:0] cv, input int robe);
    enable               = en;
    clear                = clr;
    bus.mt_rs1_tag       = TAG_W'(t1);
    bus.mt_rs1_ready     = r1;
    bus.mt_rs2_tag       = TAG_W'(t2);
    bus.mt_rs2_ready     = r2;
    bus.cdb_reg_tag      = TAG_W'(ct);
    bus.cdb_reg_value    = cv;
    bus.rob_entry        = TAG_W'(robe);
    bus.id_rs1_value     = $urandom;
    bus.id_rs2_value     = $urandom;
    bus.rob_rs1_value    = $urandom;
    bus.rob_rs2_value    = $urandom;
    bus.id_dest_reg_idx  = 5'($urandom);
    bus.id_misc          = {$urandom, $urandom};
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check_outputs();
  endtask

  initial begin
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, '0, 0);
    #12;
    check_outputs();
    chk("reset_rs1", 64'(bus.is_rs1_value), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Register-file operands, hold, then clear
    set_in(1, 0, 0, 0, 0, 0, 0, '0, 1);
    bus.id_rs1_value = 1; bus.id_rs2_value = 1; bus.id_dest_reg_idx = 1;
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, '0, 1);
    cycle(); cycle();
    set_in(0, 1, 0, 0, 0, 0, 0, '0, 1);
    cycle();

    // ROB-forwarded operands stay busy until cleared
    set_in(1, 0, 1, 1, 1, 1, 0, '0, 2);
    bus.rob_rs1_value = 0; bus.rob_rs2_value = 0;
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, '0, 2);
    cycle(); cycle();
    set_in(0, 1, 0, 0, 0, 0, 0, '0, 2);
    cycle();

    // Common tag wait, enable held twice, one broadcast wakes both
    set_in(1, 0, 1, 0, 1, 0, 0, '0, 3);
    cycle(); cycle();
    set_in(0, 0, 0, 0, 0, 0, 1, 32'd1, 3);
    cycle();
    set_in(0, 1, 0, 0, 0, 0, 0, '0, 3);
    cycle();

    // Mixed: rs1 waits on tag 2, rs2 forwarded from ROB
    set_in(1, 0, 2, 0, 3, 1, 0, '0, 4);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, '0, 4);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 2, 32'd10, 4);
    cycle();

    // Sequential wakeup, plus a non-matching broadcast
    set_in(1, 0, 3, 0, 4, 0, 0, '0, 5);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 7, 32'd99, 5);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 4, 32'd10, 5);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 3, 32'd10, 5);
    cycle();

    // Back-to-back reuse: clear and enable in the same cycle
    set_in(1, 1, 1, 1, 1, 1, 0, '0, 6);
    cycle();
    chk("reuse_rob6", 64'(bus.is_rob_entry), 64'd6);

    // Asynchronous reset mid-wait
    set_in(1, 0, 5, 0, 6, 0, 0, '0, 7);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, '0, 7);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #1 reset = 1'b1;

    // Randomized traffic, including CDB activity on an idle slot
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
             $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom, $urandom_range(0, 31));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rs_entry.md
Name: rs_entry

Overview:
- Single reservation-station slot for the out-of-order core.
- Latches one dispatched instruction: decoded info from ID, operand tags from the map table, ROB-forwarded values and the allocated ROB entry.
- Snoops the CDB for outstanding operand tags.
- Flags ready-to-issue, drives the issue packet, and frees on clear.
- The RS top instantiates N of these and does allocation and issue selection.

Parameters:
- XLEN, 32, operand value width.
- TAG_W, 5, ROB tag / rob_entry width; tag value 0 is reserved and means "no tag / register file".

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_packet_in  in  ID_PACKET  decoded instruction; uses rs1_value, rs2_value (XLEN each) and dest_reg_idx (5); all other fields pass through. Valid only when enable=1.
- mt2rs_packet_in  in  MT2RS_PACKET  rs1_tag, rs2_tag (TAG_W); rs1_ready, rs2_ready (1: tagged value already complete in ROB). Valid only when enable=1.
- cdb_packet_in  in  CDB_PACKET  reg_tag (TAG_W), reg_value (XLEN); reg_tag=0 means no broadcast.
- rob2rs_packet_in  in  ROB2RS_PACKET  rob_entry (TAG_W, allocated dest tag), rs1_value, rs2_value (XLEN, ROB-held operand values). Valid only when enable=1.
- clear  in  1  free the entry (instruction issued or squashed).
- enable  in  1  load a new instruction this cycle.
- is_packet_out  out  IS_PACKET  stored instruction: ID fields, final rs1_value/rs2_value, dest_reg_idx, rob_entry.
- busy  out  1  entry holds a valid instruction.
- ready  out  1  busy and both operands resolved.

Behaviour:
- State: busy; per operand a tag (TAG_W), value (XLEN) and valid bit; stored ID packet; rob_entry.
- Reset (reset low, async): busy=0, both valid bits 0, tags 0, values 0, is_packet_out all zeros, ready=0.
- Per-operand load rule on enable, for each operand i:
  - tag==0: value = id_packet_in.rsi_value, valid=1.
  - tag!=0 and rsi_ready=1: value = rob2rs_packet_in.rsi_value, valid=1.
  - tag!=0 and rsi_ready=0: if cdb reg_tag==tag (nonzero) the same cycle, capture reg_value and set valid=1; otherwise store tag, valid=0.
- Load: on a rising edge with enable=1, set busy=1, store the ID packet and rob_entry, and apply the operand rule above.
- Enable has priority over clear; simultaneous enable+clear loads the new instruction and busy stays 1.
- Enable while already busy overwrites the entry.
- Clear: on a rising edge with clear=1 and enable=0, busy=0, valid bits 0 and tags 0.
- Hold: with enable=0 and clear=0, busy holds indefinitely. There is no self-clear on issue.
- CDB snoop: while busy, enable=0 and clear=0, for each operand with valid=0 and tag==cdb reg_tag (reg_tag!=0), latch reg_value and set valid=1.
  - Both operands may capture from the same broadcast.
  - A broadcast with a non-matching tag leaves the entry unchanged.
- ready = busy & op1_valid & op2_valid. It is combinational from registered state only, so it rises the cycle after the resolving load or CDB edge and never directly from CDB inputs.
- Latency:
  - Operand resolved at load: ready=1 immediately after the load edge.
  - CDB-resolved operand: ready=1 after the edge that captures the broadcast.
- is_packet_out: stored ID packet with rs1_value/rs2_value replaced by the stored operand values; it also carries dest_reg_idx and rob_entry. Content is valid only when ready=1; it holds the last values when not busy.
- Must not depend on cdb_packet_in when busy=0 and enable=0.

Test Plan:
- Register-file operands: enable, tags 0/0, rs values 1/1, dest 1, rob_entry 1 -> next cycle busy=1, ready=1, operands 1/1. Enable=0 -> busy stays 1. Clear=1 -> busy=0, ready=0.
- ROB-forwarded: tags 1/1, rs_ready 1/1, rob rs values 0/0 -> busy=1, ready=1, operands from ROB. Entry stays busy until clear.
- Common tag wait: tags 1/1 not ready -> busy=1, ready=0. Enable held a second cycle -> still ready=0. CDB tag 1 value 1 -> next cycle ready=1, both operands 1. Clear -> busy=0.
- Mixed: tag1=2 waiting, tag2=3 ROB-ready -> ready=0. Idle cycle with CDB tag 0 -> ready=0. CDB tag 2 value 10 -> ready=1, rs1_value=10.
- Sequential wakeup: tags 3/4 waiting. CDB tag 4 value 10 -> ready=0. CDB tag 3 value 10 -> ready=1. Clear -> busy=0.
- Back-to-back reuse: busy entry with clear=1 and enable=1 together for a new instruction (tags 1/1 ROB-ready) -> busy remains 1 and ready=1 with the new rob_entry 6. Also pulse reset low mid-wait -> busy=0, ready=0 immediately.
